// File: rtl/avalon_crypto_mmio_ctrl.sv
// ============================================================================
// Module   : avalon_crypto_mmio_ctrl
// Brief    : Avalon-MM register file and run controller for a block-cipher core
// Revision : 1.0
// ============================================================================
`default_nettype none

module avalon_crypto_mmio_ctrl #(
    parameter int DATA_W      = 32,
    parameter int KEY_WORDS   = 4,
    parameter int MSG_WORDS   = 4,
    parameter int ADDR_W      = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                           CLK,
    input  logic                           RESET_N,
    input  logic                           AVL_READ,
    input  logic                           AVL_WRITE,
    input  logic                           AVL_CS,
    input  logic [DATA_W/8-1:0]            AVL_BYTE_EN,
    input  logic [ADDR_W-1:0]              AVL_ADDR,
    input  logic [DATA_W-1:0]              AVL_WRITEDATA,
    output logic [DATA_W-1:0]              AVL_READDATA,
    output logic [KEY_WORDS*DATA_W-1:0]    CORE_KEY,
    output logic [MSG_WORDS*DATA_W-1:0]    CORE_MSG,
    output logic                           CORE_START,
    input  logic                           CORE_DONE,
    input  logic [MSG_WORDS*DATA_W-1:0]    CORE_RESULT,
    output logic                           IRQ,
    output logic [31:0]                    EXPORT_DATA
);

    localparam int CTRL_ADDR   = 2**ADDR_W - 2;
    localparam int STATUS_ADDR = 2**ADDR_W - 1;
    localparam int RES_BASE    = KEY_WORDS + MSG_WORDS;
    localparam int WD_W        = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] key_q [KEY_WORDS];
    logic [DATA_W-1:0] key_d [KEY_WORDS];
    logic [DATA_W-1:0] msg_q [MSG_WORDS];
    logic [DATA_W-1:0] msg_d [MSG_WORDS];
    logic [DATA_W-1:0] res_q [MSG_WORDS];
    logic [DATA_W-1:0] res_d [MSG_WORDS];
    logic              irq_en_q, irq_en_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              irq_q, irq_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;

    logic [31:0]       addr_w;
    logic              wr_w, ctrl_wr_w, status_wr_w, timeout_w;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0]   old_v,
        input logic [DATA_W-1:0]   new_v,
        input logic [DATA_W/8-1:0] be
    );
        logic [DATA_W-1:0] r;
        r = old_v;
        for (int b = 0; b < DATA_W/8; b++) begin
            if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    assign addr_w      = 32'(AVL_ADDR);
    assign wr_w        = AVL_CS & AVL_WRITE;
    // Control/status bits all live in byte lane 0
    assign ctrl_wr_w   = wr_w && (addr_w == 32'(CTRL_ADDR)) && AVL_BYTE_EN[0];
    assign status_wr_w = wr_w && (addr_w == 32'(STATUS_ADDR)) && AVL_BYTE_EN[0];
    assign timeout_w   = (TIMEOUT_CYC != 0) && (wdog_q == WD_LAST);

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        msg_d    = msg_q;
        res_d    = res_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        err_d    = err_q;
        wdog_d   = '0;

        if (wr_w && state_q != ST_RUN) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                if (addr_w == 32'(i)) key_d[i] = merge_bytes(key_q[i], AVL_WRITEDATA, AVL_BYTE_EN);
            end
            for (int i = 0; i < MSG_WORDS; i++) begin
                if (addr_w == 32'(KEY_WORDS + i)) msg_d[i] = merge_bytes(msg_q[i], AVL_WRITEDATA, AVL_BYTE_EN);
            end
        end

        if (ctrl_wr_w) irq_en_d = AVL_WRITEDATA[1];
        if (status_wr_w && AVL_WRITEDATA[0]) done_d = 1'b0;
        if (status_wr_w && AVL_WRITEDATA[1]) err_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_wr_w && AVL_WRITEDATA[0]) state_d = ST_RUN;
            end
            ST_RUN: begin
                // Abort beats completion, completion beats the watchdog
                if (ctrl_wr_w && AVL_WRITEDATA[2]) begin
                    state_d = ST_IDLE;
                end else if (CORE_DONE) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    for (int i = 0; i < MSG_WORDS; i++) begin
                        res_d[i] = CORE_RESULT[(MSG_WORDS-1-i)*DATA_W +: DATA_W];
                    end
                end else if (timeout_w) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (status_wr_w && (AVL_WRITEDATA[0] || AVL_WRITEDATA[1])) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        irq_d = irq_en_d & (done_d | err_d);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            irq_q    <= 1'b0;
            wdog_q   <= '0;
            for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
            for (int i = 0; i < MSG_WORDS; i++) begin
                msg_q[i] <= '0;
                res_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            irq_q    <= irq_d;
            wdog_q   <= wdog_d;
            key_q    <= key_d;
            msg_q    <= msg_d;
            res_q    <= res_d;
        end
    end

    always_comb begin
        AVL_READDATA = '0;
        if (AVL_CS && AVL_READ) begin
            for (int i = 0; i < KEY_WORDS; i++) begin
                if (addr_w == 32'(i)) AVL_READDATA = key_q[i];
            end
            for (int i = 0; i < MSG_WORDS; i++) begin
                if (addr_w == 32'(KEY_WORDS + i)) AVL_READDATA = msg_q[i];
                if (addr_w == 32'(RES_BASE + i))  AVL_READDATA = res_q[i];
            end
            if (addr_w == 32'(CTRL_ADDR)) begin
                AVL_READDATA[0] = (state_q == ST_RUN);
                AVL_READDATA[1] = irq_en_q;
            end
            if (addr_w == 32'(STATUS_ADDR)) begin
                AVL_READDATA[0] = done_q;
                AVL_READDATA[1] = err_q;
                AVL_READDATA[2] = (state_q == ST_RUN);
            end
        end
    end

    generate
        for (genvar i = 0; i < KEY_WORDS; i++) begin : g_key_out
            assign CORE_KEY[(KEY_WORDS-1-i)*DATA_W +: DATA_W] = key_q[i];
        end
        for (genvar i = 0; i < MSG_WORDS; i++) begin : g_msg_out
            assign CORE_MSG[(MSG_WORDS-1-i)*DATA_W +: DATA_W] = msg_q[i];
        end
    endgenerate

    assign CORE_START  = (state_q == ST_RUN);
    assign IRQ         = irq_q;
    assign EXPORT_DATA = {key_q[0][31:16], key_q[KEY_WORDS-1][15:0]};

endmodule

`default_nettype wire

// File: tb/tb_avalon_crypto_mmio_ctrl.sv
// ============================================================================
// Module   : tb_avalon_crypto_mmio_ctrl
// Brief    : Directed self-checking bench for avalon_crypto_mmio_ctrl
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_avalon_crypto_mmio_ctrl;

    localparam int DATA_W    = 32;
    localparam int KEY_WORDS = 4;
    localparam int MSG_WORDS = 4;
    localparam int ADDR_W    = 4;
    localparam int TIMEOUT   = 16;

    localparam logic [3:0] A_CTRL   = 4'd14;
    localparam logic [3:0] A_STATUS = 4'd15;

    logic          CLK, RESET_N;
    logic          AVL_READ, AVL_WRITE, AVL_CS;
    logic [3:0]    AVL_BYTE_EN;
    logic [3:0]    AVL_ADDR;
    logic [31:0]   AVL_WRITEDATA, AVL_READDATA;
    logic [127:0]  CORE_KEY, CORE_MSG, CORE_RESULT;
    logic          CORE_START, CORE_DONE, IRQ;
    logic [31:0]   EXPORT_DATA;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rd;

    localparam logic [127:0] RESULT_A = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] RESULT_B = 128'hCAFEF00DCAFEF00DCAFEF00DCAFEF00D;

    avalon_crypto_mmio_ctrl #(
        .DATA_W(DATA_W), .KEY_WORDS(KEY_WORDS), .MSG_WORDS(MSG_WORDS),
        .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
        .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
        .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
        .CORE_KEY(CORE_KEY), .CORE_MSG(CORE_MSG), .CORE_START(CORE_START),
        .CORE_DONE(CORE_DONE), .CORE_RESULT(CORE_RESULT),
        .IRQ(IRQ), .EXPORT_DATA(EXPORT_DATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic avl_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] be);
        @(negedge CLK);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = addr;
        AVL_WRITEDATA = data; AVL_BYTE_EN = be;
        @(posedge CLK);
        #1;
        AVL_CS = 1'b0; AVL_WRITE = 1'b0;
    endtask

    task automatic avl_read(input logic [3:0] addr, output logic [31:0] data);
        @(negedge CLK);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = addr;
        #1;
        data = AVL_READDATA;
        AVL_CS = 1'b0; AVL_READ = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0; AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_CS = 1'b0;
        AVL_BYTE_EN = 4'h0; AVL_ADDR = 4'h0; AVL_WRITEDATA = 32'h0;
        CORE_DONE = 1'b0; CORE_RESULT = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Reset state
        check_val("rst_core_start", CORE_START, 1'b0);
        check_val("rst_irq", IRQ, 1'b0);
        check_val("rst_export", EXPORT_DATA, 32'h0);
        avl_read(A_STATUS, rd);
        check_val("rst_status", rd, 32'h0);

        // Byte-lane write
        avl_write(4'd0, 32'hDEADBEEF, 4'b0101);
        avl_read(4'd0, rd);
        check_val("be_key0", rd, 32'h00AD00EF);
        check_val("be_export", EXPORT_DATA, 32'h00AD0000);

        // Unmapped address
        avl_write(4'd12, 32'hFFFFFFFF, 4'hF);
        avl_read(4'd12, rd);
        check_val("unmapped", rd, 32'h0);

        // Load key and message
        for (int i = 0; i < 4; i++) avl_write(4'(i), 32'h1000_0000 + i, 4'hF);
        for (int i = 0; i < 4; i++) avl_write(4'(4 + i), 32'h2000_0000 + i, 4'hF);
        check_val("core_key", CORE_KEY, 128'h10000000_10000001_10000002_10000003);
        check_val("core_msg", CORE_MSG, 128'h20000000_20000001_20000002_20000003);
        check_val("export_key", EXPORT_DATA, 32'h10000003);

        // Normal run
        avl_write(A_CTRL, 32'h3, 4'hF);
        check_val("run_start", CORE_START, 1'b1);
        avl_read(A_STATUS, rd);
        check_val("run_status_busy", rd, 32'h4);
        avl_read(A_CTRL, rd);
        check_val("run_ctrl", rd, 32'h3);
        avl_write(4'd4, 32'hFFFFFFFF, 4'hF);
        check_val("lockout_msg0", CORE_MSG[127:96], 32'h20000000);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        CORE_DONE = 1'b1; CORE_RESULT = RESULT_A;
        @(posedge CLK);
        #1;
        CORE_DONE = 1'b0;
        check_val("done_irq", IRQ, 1'b1);
        check_val("done_start_low", CORE_START, 1'b0);
        avl_read(A_STATUS, rd);
        check_val("done_status", rd, 32'h1);
        avl_read(4'd8, rd);
        check_val("res0", rd, 32'h01234567);
        avl_read(4'd9, rd);
        check_val("res1", rd, 32'h89ABCDEF);
        avl_write(A_STATUS, 32'h1, 4'hF);
        check_val("w1c_irq", IRQ, 1'b0);
        avl_read(A_STATUS, rd);
        check_val("w1c_status", rd, 32'h0);
        avl_read(A_CTRL, rd);
        check_val("w1c_ctrl", rd, 32'h2);

        // Watchdog timeout: CORE_START must stay up exactly 16 cycles
        avl_write(A_CTRL, 32'h3, 4'hF);
        repeat (15) @(posedge CLK);
        #1;
        check_val("to_start_before", CORE_START, 1'b1);
        @(posedge CLK);
        #1;
        check_val("to_start_after", CORE_START, 1'b0);
        avl_read(A_STATUS, rd);
        check_val("to_status", rd, 32'h3);
        avl_read(4'd8, rd);
        check_val("to_res_kept", rd, 32'h01234567);
        check_val("to_irq", IRQ, 1'b1);
        avl_write(A_STATUS, 32'h3, 4'hF);
        avl_read(A_STATUS, rd);
        check_val("to_cleared", rd, 32'h0);

        // Abort racing a core completion
        avl_write(A_CTRL, 32'h1, 4'hF);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        CORE_DONE = 1'b1; CORE_RESULT = RESULT_B;
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = A_CTRL;
        AVL_WRITEDATA = 32'h4; AVL_BYTE_EN = 4'hF;
        @(posedge CLK);
        #1;
        AVL_CS = 1'b0; AVL_WRITE = 1'b0;
        check_val("abort_start", CORE_START, 1'b0);
        repeat (3) @(posedge CLK);
        avl_read(A_STATUS, rd);
        check_val("abort_status", rd, 32'h0);
        avl_read(4'd8, rd);
        check_val("abort_res", rd, 32'h01234567);
        check_val("abort_irq", IRQ, 1'b0);
        CORE_DONE = 1'b0;

        // Asynchronous reset mid-run
        avl_write(A_CTRL, 32'h3, 4'hF);
        check_val("arst_pre_start", CORE_START, 1'b1);
        @(posedge CLK);
        #3;
        RESET_N = 1'b0;
        #1;
        check_val("arst_start", CORE_START, 1'b0);
        check_val("arst_irq", IRQ, 1'b0);
        check_val("arst_export", EXPORT_DATA, 32'h0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        avl_read(4'd0, rd);
        check_val("arst_key0", rd, 32'h0);
        avl_read(4'd4, rd);
        check_val("arst_msg0", rd, 32'h0);
        avl_read(4'd8, rd);
        check_val("arst_res0", rd, 32'h0);
        avl_read(A_CTRL, rd);
        check_val("arst_ctrl", rd, 32'h0);
        avl_read(A_STATUS, rd);
        check_val("arst_status", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
